fpnew_result_queue: RTL and testbench
=====================================

// Module: fpnew_result_queue
// PURPOSE
//  Output-side buffer directly downstream of an opgroup block. It accepts result,
//  status, extension bit and tag through a valid/ready handshake and stores them
//  in-order in a Depth-entry FIFO, decoupling opgroup back-pressure from the
//  core's writeback port.
//  Accumulates sticky IEEE exception flags (fflags) from every retired result.
// PARAMETERS
//  Width     32  result width in bits (matches the opgroup block Width)
//  TagWidth  1   tag width in bits
//  Depth     4   FIFO entries; power of two, >= 2
// PORTS
//  clk_i         in   1             clock, all state on rising edge
//  rst_i         in   1             synchronous reset, active-high
//  flush_i       in   1             drop all buffered entries
//  in_valid_i    in   1             upstream result valid
//  in_ready_o    out  1             queue can accept
//  result_i      in   Width         upstream result
//  status_i      in   5             {NV,DZ,OF,UF,NX}
//  ext_bit_i     in   1             upstream extension bit
//  tag_i         in   TagWidth      upstream tag
//  out_valid_o   out  1             head entry valid
//  out_ready_i   in   1             consumer accepts head
//  result_o      out  Width         head result
//  status_o      out  5             head status
//  ext_bit_o     out  1             head extension bit
//  tag_o         out  TagWidth      head tag
//  fflags_clr_i  in   1             clear sticky flags
//  fflags_o      out  5             sticky OR of status of all popped entries
//  usage_o       out  $clog2(Depth+1)  occupied entries
//  busy_o        out  1             usage_o != 0
// BEHAVIOUR
//  - Reset: rd/wr pointers = 0, usage_o = 0, fflags_o = 0, out_valid_o = 0,
//    busy_o = 0, in_ready_o = 1. Data outputs are don't-care while out_valid_o = 0.
//  - Reset mid-operation discards all entries; there is no partial drain.
//  - Push when in_valid_i & in_ready_o. Pop when out_valid_o & out_ready_i.
//  - in_ready_o = (usage_o != Depth). No combinational path from out_ready_i.
//  - Full: in_ready_o = 0 even if a pop occurs in the same cycle.
//  - Empty: out_valid_o = 0.
//  - Simultaneous push and pop when not full: usage unchanged, both pointers advance.
//  - Pointers are log2(Depth) bits and wrap modulo Depth.
//  - usage_o counts 0..Depth.
//  - Latency (no bypass): an entry pushed in cycle N is visible at the head in
//    cycle N+1. Output is the registered FIFO head, in strict push order.
//  - Head data is stable while out_valid_o & !out_ready_i.
//  - flush_i: next cycle usage_o = 0 and pointers = 0.
//    A push or pop in the flush cycle is ignored; in_ready_o is still reported.
//    fflags_o is unaffected by flush.
//  - fflags next value = (fflags_clr_i ? 0 : fflags_o) | (pop ? status_o : 0).
//    A set in the clear cycle wins.
//    Priority: rst_i > flush_i > normal operation.
// CONFIGURATION
//  FPNEW_RESULT_QUEUE_BYPASS_EN
//   defined: when usage_o == 0 and not flushing, out_valid_o = in_valid_i and head
//    outputs = inputs combinationally (0-cycle latency).
//    If out_ready_i is high the entry is consumed without being written.
//    Otherwise it is written, and the next cycle presents it from storage.
//    fflags accumulate on bypassed pops identically.
//    in_ready_o is unchanged (= not full).
//   undefined: no bypass; latency is always >= 1 cycle; no combinational
//    input-to-output path.
// TESTING
//  1 Reset, then push A (result=32'h3F80_0000, status=5'b00001, tag=1) with
//    out_ready_i=1 -> out_valid_o rises next cycle; result_o=32'h3F80_0000;
//    one cycle later fflags_o=5'b00001.
//  2 out_ready_i=0, push 4 entries (Depth=4) -> usage_o=4, in_ready_o=0;
//    a 5th push is refused.
//    Raise out_ready_i -> pops in push order; in_ready_o=1 the cycle after the
//    first pop.
//  3 Steady stream with in_valid_i=out_ready_i=1 for 20 cycles -> one result per
//    cycle, usage_o stays 1; pointers wrap at least 4 times with no loss or
//    reordering.
//  4 Queue holds 3 entries; assert flush_i together with a push ->
//    next cycle usage_o=0, out_valid_o=0; the pushed entry never appears;
//    fflags_o retained.
//  5 fflags_o=5'b10000; same cycle fflags_clr_i=1 and pop with status=5'b00100
//    -> fflags_o=5'b00100.
//  6 With FPNEW_RESULT_QUEUE_BYPASS_EN, empty queue, in_valid_i=out_ready_i=1
//    -> out_valid_o=1 in the same cycle; usage_o stays 0.
//    Without the macro -> out_valid_o=1 one cycle later.

Source files
------------

// File: rtl/fpnew_result_queue.sv
// -----------------------------------------------------------------------------
// fpnew_result_queue
//
// Purpose:
//   In-order result buffer placed directly after an opgroup block. Results,
//   IEEE status flags, the extension bit and the tag are accepted through a
//   valid/ready handshake and held in a Depth-entry FIFO. This decouples
//   opgroup back-pressure from the core's writeback port. The status of every
//   retired (popped) entry is OR-ed into a sticky fflags register.
//
// Configuration macro:
//   FPNEW_RESULT_QUEUE_BYPASS_EN
//     defined   : when the queue is empty and not flushing, the input is
//                 presented at the head combinationally (0-cycle latency).
//                 An entry consumed in that same cycle is never written.
//     undefined : no bypass; every entry spends at least one cycle in storage
//                 and there is no combinational input-to-output path.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                drop every buffered entry (fflags kept)
//   in_valid_i/in_ready_o  upstream handshake; ready = not full
//   result_i, status_i, ext_bit_i, tag_i   upstream payload
//   out_valid_o/out_ready_i                downstream handshake
//   result_o, status_o, ext_bit_o, tag_o   head payload
//   fflags_clr_i, fflags_o                 sticky exception flags
//   usage_o, busy_o                        occupancy, non-empty indicator
// -----------------------------------------------------------------------------
module fpnew_result_queue #(
    parameter int unsigned Width    = 32,
    parameter int unsigned TagWidth = 1,
    parameter int unsigned Depth    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  logic [4:0]                 status_i,
    input  logic                       ext_bit_i,
    input  logic [TagWidth-1:0]        tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       ext_bit_o,
    output logic [TagWidth-1:0]        tag_o,
    input  logic                       fflags_clr_i,
    output logic [4:0]                 fflags_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned UsageW = $clog2(Depth + 1);
    localparam int unsigned EntryW = Width + 5 + 1 + TagWidth;
    localparam logic [UsageW-1:0] FullUsage = UsageW'(Depth);

    // Storage and state.
    logic [EntryW-1:0] mem_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [UsageW-1:0] usage_r;
    logic [4:0]        fflags_r;

    // Combinational control.
    logic [EntryW-1:0] in_entry_s;
    logic [EntryW-1:0] head_entry_s;
    logic              full_s;
    logic              empty_s;
    logic              bypass_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              bypass_consume_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              flag_pop_s;
    logic [4:0]        fflags_next_s;
    logic [UsageW-1:0] usage_next_s;

    assign in_entry_s = {result_i, status_i, ext_bit_i, tag_i};

    // Handshake decode, head selection and next-state computation.
    always_comb begin
        full_s  = (usage_r == FullUsage);
        empty_s = (usage_r == {UsageW{1'b0}});
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        bypass_s = empty_s & ~flush_i;
`else
        bypass_s = 1'b0;
`endif
        if (bypass_s) begin
            out_valid_s  = in_valid_i;
            head_entry_s = in_entry_s;
        end else begin
            out_valid_s  = ~empty_s;
            head_entry_s = mem_r[rd_ptr_r];
        end

        // Full stays full for the whole cycle even if a pop happens.
        push_s = in_valid_i & ~full_s;
        pop_s  = out_valid_s & out_ready_i;

        // A bypassed entry taken in the same cycle never touches storage.
        bypass_consume_s = bypass_s & push_s & out_ready_i;
        wr_en_s          = push_s & ~bypass_consume_s & ~flush_i;
        rd_en_s          = pop_s & ~bypass_s & ~flush_i;
        flag_pop_s       = pop_s & ~flush_i;

        // Clear first, then OR in the retiring status so a set wins.
        if (fflags_clr_i) begin
            fflags_next_s = 5'b00000;
        end else begin
            fflags_next_s = fflags_r;
        end
        if (flag_pop_s) begin
            fflags_next_s = fflags_next_s | head_entry_s[TagWidth+1 +: 5];
        end else begin
            fflags_next_s = fflags_next_s;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   usage_next_s = usage_r + {{(UsageW-1){1'b0}}, 1'b1};
            2'b01:   usage_next_s = usage_r - {{(UsageW-1){1'b0}}, 1'b1};
            default: usage_next_s = usage_r;
        endcase
    end

    // Pointer, occupancy and sticky-flag registers; reset > flush > normal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            usage_r  <= {UsageW{1'b0}};
            fflags_r <= 5'b00000;
        end else if (flush_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            usage_r  <= {UsageW{1'b0}};
            fflags_r <= fflags_next_s;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            usage_r  <= usage_next_s;
            fflags_r <= fflags_next_s;
        end
    end

    // Payload storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    assign in_ready_o  = ~full_s;
    assign out_valid_o = out_valid_s;
    assign result_o    = head_entry_s[EntryW-1 -: Width];
    assign status_o    = head_entry_s[TagWidth+1 +: 5];
    assign ext_bit_o   = head_entry_s[TagWidth];
    assign tag_o       = head_entry_s[TagWidth-1:0];
    assign fflags_o    = fflags_r;
    assign usage_o     = usage_r;
    assign busy_o      = ~empty_s;

endmodule

// File: tb/tb_fpnew_result_queue.sv
// Randomized and directed stimulus for fpnew_result_queue, checked against a
// queue-based reference model of the buffer and its sticky flags.
module tb_fpnew_result_queue;

    localparam int W  = 32;
    localparam int TW = 1;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  result_i = '0;
    logic [4:0]    status_i = '0;
    logic          ext_bit_i = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  result_o;
    logic [4:0]    status_o;
    logic          ext_bit_o;
    logic [TW-1:0] tag_o;
    logic          fflags_clr_i = 1'b0;
    logic [4:0]    fflags_o;
    logic [2:0]    usage_o;
    logic          busy_o;

    always #5 clk = ~clk;

    fpnew_result_queue #(.Width(W), .TagWidth(TW), .Depth(D)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i), .ext_bit_i(ext_bit_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .ext_bit_o(ext_bit_o), .tag_o(tag_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o),
        .usage_o(usage_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [W-1:0]  res;
        logic [4:0]    st;
        logic          ext;
        logic [TW-1:0] tag;
    } ent_t;

    ent_t        m_q[$];
    logic [4:0]  m_flags;
    bit          m_known = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic run_cycle(input logic rst, input logic flush, input logic iv,
                             input logic ordy, input logic clr, input logic [W-1:0] res,
                             input logic [4:0] st, input logic ext, input logic [TW-1:0] tg);
        ent_t in_e;
        ent_t head;
        bit   byp;
        bit   exp_valid;
        bit   exp_ready;
        bit   push;
        bit   pop;
        @(negedge clk);
        rst_i = rst; flush_i = flush; in_valid_i = iv; out_ready_i = ordy;
        fflags_clr_i = clr; result_i = res; status_i = st; ext_bit_i = ext; tag_i = tg;
        #1;
        in_e = '{res: res, st: st, ext: ext, tag: tg};
        byp = 1'b0;
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        byp = (m_q.size() == 0) && !flush;
`endif
        if (byp) begin
            exp_valid = iv;
            head = in_e;
        end else begin
            exp_valid = (m_q.size() != 0);
            head = exp_valid ? m_q[0] : in_e;
        end
        exp_ready = (m_q.size() != D);
        if (m_known) begin
            check_val("out_valid", out_valid_o, exp_valid);
            check_val("in_ready", in_ready_o, exp_ready);
            check_val("usage", usage_o, m_q.size());
            check_val("busy", busy_o, m_q.size() != 0);
            check_val("fflags", fflags_o, m_flags);
            if (exp_valid) begin
                check_val("result", result_o, head.res);
                check_val("status", status_o, head.st);
                check_val("ext_bit", ext_bit_o, head.ext);
                check_val("tag", tag_o, head.tag);
            end
        end
        push = iv && exp_ready;
        pop  = exp_valid && ordy;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_flags = 5'b00000;
            m_known = 1'b1;
        end else if (flush) begin
            m_q.delete();
            if (clr) m_flags = 5'b00000;
        end else begin
            m_flags = (clr ? 5'b00000 : m_flags) | (pop ? head.st : 5'b00000);
            if (byp) begin
                if (push && !ordy) m_q.push_back(in_e);
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(in_e);
            end
        end
    endtask

    task automatic idle_cycle(input logic ordy);
        run_cycle(1'b0, 1'b0, 1'b0, ordy, 1'b0, '0, 5'b00000, 1'b0, '0);
    endtask

    task automatic push_cycle(input logic ordy, input logic [W-1:0] res, input logic [4:0] st,
                              input logic tg);
        run_cycle(1'b0, 1'b0, 1'b1, ordy, 1'b0, res, st, res[0], tg);
    endtask

    initial begin
        // Reset, then a single push drained immediately.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 5'b00000, 1'b0, '0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 5'b00000, 1'b0, '0);
        push_cycle(1'b1, 32'h3F80_0000, 5'b00001, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        #2 check_val("t1_fflags", fflags_o, 5'b00001);

        // Fill to full, attempt a fifth push, then drain in order.
        for (int i = 0; i < 5; i++) push_cycle(1'b0, 32'h1000_0000 + i, 5'(1 << (i % 5)), i[0]);
        #2 check_val("t2_usage_full", usage_o, 3'd4);
        check_val("t2_ready_full", in_ready_o, 1'b0);
        for (int i = 0; i < 5; i++) idle_cycle(1'b1);

        // Steady stream: one result per cycle, occupancy constant.
        push_cycle(1'b0, 32'h2000_0000, 5'b00000, 1'b0);
        for (int i = 1; i <= 20; i++) push_cycle(1'b1, 32'h2000_0000 + i, 5'b00000, i[0]);
        for (int i = 0; i < 2; i++) idle_cycle(1'b1);

        // Three held entries, flush together with a push.
        for (int i = 0; i < 3; i++) push_cycle(1'b0, 32'h3000_0000 + i, 5'b00010, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'b11111, 1'b1, 1'b1);
        #2 check_val("t4_usage", usage_o, 3'd0);
        check_val("t4_valid", out_valid_o, 1'b0);
        check_val("t4_fflags", fflags_o, m_flags);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Clear and set of the sticky flags in the same cycle.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 5'b00000, 1'b0, '0);
        push_cycle(1'b1, 32'h4000_0000, 5'b10000, 1'b0);
        idle_cycle(1'b1);
        push_cycle(1'b0, 32'h4000_0001, 5'b00100, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 5'b00000, 1'b0, '0);
        #2 check_val("t5_fflags", fflags_o, 5'b00100);

        // Empty queue, valid and ready together.
        idle_cycle(1'b1);
        @(negedge clk);
        in_valid_i = 1'b1; out_ready_i = 1'b1; result_i = 32'h5555_AAAA;
        status_i = 5'b00000; fflags_clr_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
        #1;
`ifdef FPNEW_RESULT_QUEUE_BYPASS_EN
        check_val("t6_valid_same", out_valid_o, 1'b1);
        check_val("t6_result_same", result_o, 32'h5555_AAAA);
        @(posedge clk); m_flags = m_flags | 5'b00000;
        #2 check_val("t6_usage", usage_o, 3'd0);
`else
        check_val("t6_valid_same", out_valid_o, 1'b0);
        @(posedge clk); m_q.push_back('{res: 32'h5555_AAAA, st: 5'b00000, ext: 1'b0, tag: 1'b0});
        #2 check_val("t6_valid_next", out_valid_o, 1'b1);
        check_val("t6_result_next", result_o, 32'h5555_AAAA);
`endif
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Randomized traffic with occasional flush, clear and reset.
        for (int i = 0; i < 800; i++) begin
            logic r;
            logic f;
            r = ($urandom_range(99) == 0);
            f = ($urandom_range(24) == 0);
            run_cycle(r, f, ($urandom_range(9) < 7), f ? 1'b0 : ($urandom_range(9) < 6),
                      ($urandom_range(9) == 0), $urandom, 5'($urandom), 1'($urandom),
                      TW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
